// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and helpers for the signed sequential divider (div_seq_ctrl).
package div_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    // Packs the HI/LO result word: remainder in the upper half, quotient in the lower.
    function automatic logic [2*WIDTH_DEF-1:0] pack_result(
        input logic [WIDTH_DEF-1:0] rem,
        input logic [WIDTH_DEF-1:0] quo
    );
        return {rem, quo};
    endfunction

endpackage

// File: rtl/div_seq_ctrl_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] absb,
    output logic [WIDTH:0]   r_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH+1:0] r_sh;
    logic [WIDTH+1:0] trial;
    logic             neg;

    // Shift {R,Q} left one bit, then try to subtract the divisor magnitude.
    // One guard bit above R keeps the sign test exact for every operand.
    always_comb begin
        r_sh  = {r, q[WIDTH-1]};
        trial = r_sh - {2'b00, absb};
        neg   = trial[WIDTH+1];
        r_nxt = neg ? r_sh[WIDTH:0] : trial[WIDTH:0];
        q_nxt = {q[WIDTH-2:0], ~neg};
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for signed 32-bit division: restoring algorithm, one step per clock,
// with sign fix-up and a registered {remainder, quotient} result.
// Optional feature macro: DIV_BY_ZERO_TRAP_EN (divide-by-zero short cut and flag).
//
// state | meaning
// IDLE  | waiting for start
// PREP  | operands captured, magnitudes and signs being formed
// ITER  | one restoring step per clock, WIDTH steps
// FIX   | apply signs, register result
// DONE  | result valid (done pulse), start may chain the next divide
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
`ifdef DIV_BY_ZERO_TRAP_EN
    output logic                 div_by_zero,
`endif
    output logic [2*WIDTH-1:0]   result
);

    div_state_t         state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   abs_b;
    logic               sign_a;
    logic               sign_q;
    logic [WIDTH:0]     r;
    logic [WIDTH-1:0]   q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     r_nxt;
    logic [WIDTH-1:0]   q_nxt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r     (r),
        .q     (q),
        .absb  (abs_b),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt)
    );

    // Main FSM: sequencing, datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            abs_b  <= '0;
            sign_a <= 1'b0;
            sign_q <= 1'b0;
            r      <= '0;
            q      <= '0;
            cnt    <= '0;
`ifdef DIV_BY_ZERO_TRAP_EN
            div_by_zero <= 1'b0;
`endif
        end else if (flush) begin
            // Abort leaves the previous result visible.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DIV_BY_ZERO_TRAP_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
`ifdef DIV_BY_ZERO_TRAP_EN
                    div_by_zero <= 1'b0;
`endif
                    if (start) begin
                        a_reg <= A;
                        b_reg <= B;
                        busy  <= 1'b1;
                        state <= PREP;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                PREP: begin
                    // Magnitudes are unsigned, so -2^(WIDTH-1) maps to 1 << (WIDTH-1).
                    sign_a <= a_reg[WIDTH-1];
                    sign_q <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
                    abs_b  <= b_reg[WIDTH-1] ? -b_reg : b_reg;
                    q      <= a_reg[WIDTH-1] ? -a_reg : a_reg;
                    r      <= '0;
                    cnt    <= '0;
`ifdef DIV_BY_ZERO_TRAP_EN
                    state  <= (b_reg == '0) ? FIX : ITER;
`else
                    state  <= ITER;
`endif
                end
                ITER: begin
                    r   <= r_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= pack_result(sign_a ? -r[WIDTH-1:0] : r[WIDTH-1:0],
                                          sign_q ? -q : q);
`ifdef DIV_BY_ZERO_TRAP_EN
                    if (b_reg == '0) begin
                        result      <= pack_result(a_reg, '1);
                        div_by_zero <= 1'b1;
                    end
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases plus random operands
// compared against an arithmetic model of signed truncating division.
module tb_div_seq_ctrl;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        flush;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] result;
`ifdef DIV_BY_ZERO_TRAP_EN
    logic        div_by_zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    div_seq_ctrl dut (
        .clock  (clock),
        .clear  (clear),
        .start  (start),
        .flush  (flush),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
`ifdef DIV_BY_ZERO_TRAP_EN
        .div_by_zero (div_by_zero),
`endif
        .result (result)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed division truncating toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qq, rr;
        if (b == 32'd0) begin
`ifdef DIV_BY_ZERO_TRAP_EN
            return {a, 32'hFFFF_FFFF};
`else
            return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
`endif
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        qq = sa / sb;
        rr = sa % sb;
        return {rr[31:0], qq[31:0]};
    endfunction

    function automatic int latency(input logic [31:0] b);
`ifdef DIV_BY_ZERO_TRAP_EN
        if (b == 32'd0) return 2;
`endif
        return 34;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits up to a bound for done; returns the edge count after E0 (bound+1 on timeout).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        if (!done) n = 101;
    endtask

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b);
        int n;
        start = 1'b1;
        A = a;
        B = b;
        tick();                              // E0
        start = 1'b0;
        A = ~a;
        B = ~b;
        chk({tag, "_busy_e0"}, 64'(busy), 64'd1);
        wait_done(n);
        chk({tag, "_done_edge"}, 64'(n), 64'(latency(b)));
        chk({tag, "_result"}, result, model(a, b));
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
`ifdef DIV_BY_ZERO_TRAP_EN
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(b == 32'd0));
`endif
        tick();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        logic [63:0] held;
        logic [31:0] ra, rb;

        clear = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        A = '0;
        B = '0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        clear = 1'b0;
        tick();

        // 100/7 with explicit busy profile over E0..E34
        start = 1'b1;
        A = 32'd100;
        B = 32'd7;
        tick();                              // E0
        start = 1'b0;
        for (int e = 1; e <= 33; e++) begin
            tick();
            if (e == 1 || e == 33) chk("p100_busy_hold", 64'(busy), 64'd1);
            if (e == 33) chk("p100_no_early_done", 64'(done), 64'd0);
        end
        tick();                              // E34
        chk("p100_done_e34", 64'(done), 64'd1);
        chk("p100_busy_e34", 64'(busy), 64'd0);
        chk("p100_result", result, 64'h0000_0002_0000_000E);
        tick();
        chk("p100_done_e35", 64'(done), 64'd0);

        do_div("n100_7", 32'hFFFF_FF9C, 32'd7);
        chk("n100_7_const", result, 64'hFFFF_FFFE_FFFF_FFF2);
        do_div("p100_n7", 32'd100, 32'hFFFF_FFF9);
        chk("p100_n7_const", result, 64'h0000_0002_FFFF_FFF2);
        do_div("min_n1", 32'h8000_0000, 32'hFFFF_FFFF);
        chk("min_n1_const", result, 64'h0000_0000_8000_0000);
        do_div("min_p1", 32'h8000_0000, 32'd1);
        do_div("p7_min", 32'd7, 32'h8000_0000);
        chk("p7_min_const", result, 64'h0000_0007_0000_0000);
        do_div("p5_z", 32'd5, 32'd0);
        chk("p5_z_const", result, 64'h0000_0005_FFFF_FFFF);
        do_div("n5_z", 32'hFFFF_FFFB, 32'd0);

        // Back-to-back with start held; operand changes after E0 must not leak in
        start = 1'b1;
        A = 32'd20;
        B = 32'd3;
        tick();                              // E0
        A = 32'd9;
        B = 32'd9;
        wait_done(n);
        chk("b2b_first_edge", 64'(n), 64'd34);
        chk("b2b_first_result", result, 64'h0000_0002_0000_0006);
        tick();                              // E35 = second E0
        start = 1'b0;
        chk("b2b_gap_done", 64'(done), 64'd0);
        chk("b2b_gap_busy", 64'(busy), 64'd1);
        wait_done(n);
        chk("b2b_second_edge", 64'(n + 35), 64'd69);
        chk("b2b_second_result", result, 64'h0000_0000_0000_0001);
        tick();

        // Flush at E10: IDLE at E11, no done, result kept
        held = result;
        start = 1'b1;
        A = 32'd50;
        B = 32'd3;
        tick();                              // E0
        start = 1'b0;
        for (int e = 1; e <= 10; e++) tick();
        flush = 1'b1;
        start = 1'b1;
        tick();                              // E11
        flush = 1'b0;
        start = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        n = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (done) n++;
        end
        chk("flush_no_done", 64'(n), 64'd0);
        chk("flush_result_kept", result, held);

        // Clear at E5 with start high
        start = 1'b1;
        A = 32'd77;
        B = 32'd5;
        tick();
        for (int e = 1; e <= 4; e++) tick();
        clear = 1'b1;
        tick();                              // E5
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_result", result, 64'd0);
`ifdef DIV_BY_ZERO_TRAP_EN
        chk("clr_dbz", 64'(div_by_zero), 64'd0);
`endif
        clear = 1'b0;
        start = 1'b0;
        tick();
        chk("clr_idle_busy", 64'(busy), 64'd0);

        // Random operands, with occasional small/zero/extreme divisors
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom_range(0, 3);
                1: rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
                2: rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            if (i % 7 == 3) ra = 32'h8000_0000;
            do_div("rand", ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Multi-cycle sequencer for signed 32-bit integer division in the CPU's mul/div unit. It accepts a dividend/divisor pair on a start strobe, runs one restoring-division step per clock, applies sign fix-up, and registers the packed {remainder, quotient} word for the HI/LO registers. While it is busy, the control unit stalls.

## Interface
- WIDTH, 32: operand width. The result is 2*WIDTH bits.
- clock  in  1  rising-edge clock.
- clear  in  1  reset: synchronous, active-high.
- start  in  1  request a divide. Sampled only in IDLE or DONE.
- flush  in  1  synchronous abort of an in-flight divide.
- A  in  WIDTH  signed dividend. Captured at the accepting edge.
- B  in  WIDTH  signed divisor. Captured at the accepting edge.
- busy  out  1  an operation is in progress; the control unit stalls.
- done  out  1  one-cycle pulse: result is valid.
- result  out  2*WIDTH  {remainder, quotient}, registered.
- div_by_zero  out  1  present only with DIV_BY_ZERO_TRAP_EN; high together with done.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE/DONE → PREP on start=1. Captures A and B.
- PREP → ITER:
  - signA = A[MSB], signB = B[MSB], signQ = signA ^ signB.
  - absA and absB are two's-complement magnitudes, treated as unsigned WIDTH bits, so -2^31 gives magnitude 0x8000_0000.
  - Partial remainder R (WIDTH+1 bits) = 0. Quotient shift register Q = absA. Step counter = 0.
- ITER step, one per edge:
  - {R,Q} shifts left 1.
  - Trial difference T = R − absB, computed in WIDTH+1 bits.
  - If T is non-negative: R = T and Q[0] = 1. Otherwise R is unchanged and Q[0] = 0.
  - The counter increments. At count = WIDTH−1, go to FIX.
- FIX → DONE:
  - quotient = signQ ? −Q : Q.
  - remainder = signA ? −R[WIDTH-1:0] : R[WIDTH-1:0].
  - result is registered; done = 1.
- DONE → IDLE if start=0. DONE → PREP if start=1 (back-to-back operation).
- flush=1 in any state: next state IDLE, busy=0, done=0, result unchanged. flush takes priority over start.
- clear=1: state IDLE. result = 0, busy = 0, done = 0, div_by_zero = 0. clear takes priority over flush and start.
- start in PREP/ITER/FIX is ignored: no queueing, no effect on captured operands.
- result changes only at the FIX edge and holds through later operations until the next FIX.
- Boundary values:
  - −2^31 / −1 → {0, 0x8000_0000}.
  - −2^31 / 1 → {0, 0x8000_0000}.
  - The remainder's sign always matches the dividend's sign.

## Timing
Let E0 be the edge where start is accepted.
- E0: state becomes PREP; busy=1.
- E1: ITER begins.
- E2..E(WIDTH+1): WIDTH iteration edges.
- E(WIDTH+2): FIX edge. result is registered and done=1.
- E(WIDTH+3): done=0. With WIDTH=32, done is high between E34 and E35.
- busy is high from E0 until the FIX edge and low in DONE and IDLE.
- With start held high in DONE, the next operation's E0 is the edge that leaves DONE. Throughput is one divide per WIDTH+3 cycles.

## Configuration
- DIV_BY_ZERO_TRAP_EN defined:
  - PREP checks B == 0. If so, next state is FIX, skipping ITER.
  - FIX registers result = {A, all-ones} and div_by_zero = 1. done follows at E2.
  - div_by_zero clears with done.
- Undefined:
  - No div_by_zero port.
  - B == 0 runs the full WIDTH iterations with no special case.
  - Result for A ≥ 0: {A, 0xFFFF_FFFF}. Result for A < 0: {A, 0x0000_0001}.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, PREP, ITER, FIX, DONE);
  - the WIDTH default;
  - a localparam for counter width = $clog2(WIDTH);
  - the result-packing helper {rem, quo}.
- Sub-module div_step: a combinational single restoring step. Inputs R, Q, absB. Outputs next R and next Q. Instantiated once and driven by the FSM.

## Test plan
- 100 / 7 → result = {0x0000_0002, 0x0000_000E}; done exactly at E34; busy high E0–E33.
- −100 / 7 → {0xFFFF_FFFE, 0xFFFF_FFF2}.
- 100 / −7 → {0x0000_0002, 0xFFFF_FFF2}.
- −2^31 / −1 → {0, 0x8000_0000}.
- 7 / −2^31 → {7, 0}.
- start held high across two back-to-back divides (20/3 then 9/9) → done pulses at E34 and E69; results {2,6} then {0,1}.
- flush asserted at E10 → IDLE at E11; no done; result keeps its previous value.
- clear at E5 with start also high → every output reset.
- 5 / 0:
  - with DIV_BY_ZERO_TRAP_EN: done at E2, div_by_zero=1, result {5, 0xFFFF_FFFF};
  - without: done at E34, result {5, 0xFFFF_FFFF}.
